// File: rtl/rx_tx_byte_queue.sv
// rx_tx_byte_queue: byte FIFO between the serial receiver and the serial sender.
// Each 0->1 edge on rx_status pushes rx_data. A three-state pop FSM launches one
// byte at a time to the sender and follows its idle/busy status.
// Optional build macro RX_TX_BYTE_QUEUE_DROP_COUNT_EN adds an 8-bit saturating
// drop_count output that counts dropped pushes and timeout discards.
//
// Sender handshake: in IDLE, when the queue holds a byte and tx_status==1, the
// head byte is registered onto tx_data and tx_en is raised. tx_en and tx_data
// then stay stable until the sender reports busy (tx_status==0) or
// BUSY_TIMEOUT cycles pass. The FSM then waits for tx_status==1 before it
// launches again.
module rx_tx_byte_queue #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 20832
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_status,
  input  logic              tx_status,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              timeout,
  output logic [1:0]        o_dbg_state
`ifdef RX_TX_BYTE_QUEUE_DROP_COUNT_EN
  ,
  output logic [7:0]        drop_count
`endif
);

  localparam int TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_rx_prev;
  logic              r_overflow;
  logic              r_timeout;
  state_t            r_state;
  logic [7:0]        r_tx_data;
  logic              r_tx_en;
  logic [TO_W-1:0]   r_to_cnt;

  logic              w_push_req;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_drop;
  logic              w_to_hit;
  logic              w_full;
  logic              w_empty;
  logic [7:0]        w_head;

  assign w_full     = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_push_req = rx_status & ~r_rx_prev;
  assign w_pop      = (r_state == ST_IDLE) & ~w_empty & tx_status;
  // A push while full survives only if a pop frees a slot on the same edge.
  assign w_push_ok  = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_to_hit   = (r_state == ST_WAIT_BUSY) & tx_status &
                      (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1));

  assign tx_data     = r_tx_data;
  assign tx_en       = r_tx_en;
  assign count       = r_count;
  assign empty       = w_empty;
  assign full        = w_full;
  assign overflow    = r_overflow;
  assign timeout     = r_timeout;
  assign o_dbg_state = r_state;

  // Storage array; a pop reads the old head before a same-edge write lands.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= rx_data;
  end

  // Edge detect, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_prev  <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rx_prev <= rx_status;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Pop FSM: launch head byte, wait for the sender to go busy, then idle again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tx_data <= 8'h00;
      r_tx_en   <= 1'b0;
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx_data <= w_head;
            r_tx_en   <= 1'b1;
            r_to_cnt  <= '0;
            r_state   <= ST_WAIT_BUSY;
          end else begin
            r_tx_en <= 1'b0;
          end
        end
        ST_WAIT_BUSY: begin
          if (!tx_status) begin
            r_tx_en <= 1'b0;
            r_state <= ST_WAIT_DONE;
          end else if (w_to_hit) begin
            r_tx_en   <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          r_tx_en <= 1'b0;
          if (tx_status) r_state <= ST_IDLE;
        end
        default: begin
          r_tx_en <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RX_TX_BYTE_QUEUE_DROP_COUNT_EN
  logic [7:0] r_drop_count;
  logic [8:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_drop_count} + {7'd0, w_drop} + {7'd0, w_to_hit};
  assign drop_count = r_drop_count;

  // Saturating count of dropped pushes and timeout discards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= 8'd0;
    end else if (w_drop_sum > 9'd255) begin
      r_drop_count <= 8'd255;
    end else begin
      r_drop_count <= w_drop_sum[7:0];
    end
  end
`endif

endmodule
